add_pipe: RTL and testbench



---
 rtl/add_pipe.sv | 111 +++++++++++
 tb/tb_add_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor: each stage adds one WIDTH/STAGES-bit
// slice, carrying the pending operand slices and the partial sum with the token.
module add_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  function automatic logic [S:0] slice_add(input logic [S-1:0] x, input logic [S-1:0] y,
                                           input logic ci);
    return {1'b0, x} + {1'b0, y} + {{S{1'b0}}, ci};
  endfunction

  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] sum_q  [STAGES];
  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] bx_q   [STAGES];
  logic             cy_q   [STAGES];
  logic             ovf_q;
  logic             zero_q;

  logic             vld_d  [STAGES];
  logic [WIDTH-1:0] psum_d [STAGES];
  logic [WIDTH-1:0] a_d    [STAGES];
  logic [WIDTH-1:0] bx_d   [STAGES];
  logic             ci_d   [STAGES];
  logic [WIDTH-1:0] sum_d  [STAGES];
  logic             cy_d   [STAGES];
  logic             ovf_d;
  logic             zero_d;
  logic             adv;
  logic [S:0]       t;

  always_comb begin
    adv       = !vld_q[L] || out_ready;
    t         = '0;
    vld_d[0]  = in_valid;
    a_d[0]    = a;
    bx_d[0]   = sub ? ~b : b;
    ci_d[0]   = sub ? 1'b1 : c_in;
    psum_d[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      a_d[i]    = a_q[i-1];
      bx_d[i]   = bx_q[i-1];
      ci_d[i]   = cy_q[i-1];
      psum_d[i] = sum_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      t                 = slice_add(a_d[i][i*S +: S], bx_d[i][i*S +: S], ci_d[i]);
      sum_d[i]          = psum_d[i];
      sum_d[i][i*S +: S] = t[S-1:0];
      cy_d[i]           = t[S];
    end
    ovf_d  = (a_d[L][WIDTH-1] == bx_d[L][WIDTH-1]) && (sum_d[L][WIDTH-1] != a_d[L][WIDTH-1]);
    zero_d = ~|sum_d[L];
  end

  // Stage registers: the whole pipe shifts on adv; data only loads behind a valid token
  // so the final-stage outputs keep the last result instead of tracking bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= 1'b0;
        sum_q[i] <= '0;
        cy_q[i]  <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= vld_d[i];
        if (vld_d[i]) begin
          sum_q[i] <= sum_d[i];
          cy_q[i]  <= cy_d[i];
          a_q[i]   <= a_d[i];
          bx_q[i]  <= bx_d[i];
        end
      end
      if (vld_d[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[L];
  assign sum       = sum_q[L];
  assign c_out     = cy_q[L];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: directed vectors, back-pressure, reset flush,
// and a random sweep over (64,1), (64,8), (32,2) instances.
module tb_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, c_in, sub;
  logic [63:0] a, b;
  logic        in_ready, out_valid, c_out, ovf, zero;
  logic [63:0] sum;

  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic        s1_ir, s1_v, s1_c, s1_o, s1_z;
  logic        s8_ir, s8_v, s8_c, s8_o, s8_z;
  logic        s32_ir, s32_v, s32_c, s32_o, s32_z;
  logic [63:0] s1_sum, s8_sum;
  logic [31:0] s32_sum;

  add_pipe dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
                .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
                .c_out(c_out), .ovf(ovf), .zero(zero));
  add_pipe #(.WIDTH(64), .STAGES(1)) d1 (.clk(clk), .rst(rst), .in_valid(sw_valid),
                .in_ready(s1_ir), .a(sw_a), .b(sw_b), .c_in(sw_cin), .sub(sw_sub),
                .out_valid(s1_v), .out_ready(1'b1), .sum(s1_sum), .c_out(s1_c), .ovf(s1_o),
                .zero(s1_z));
  add_pipe #(.WIDTH(64), .STAGES(8)) d8 (.clk(clk), .rst(rst), .in_valid(sw_valid),
                .in_ready(s8_ir), .a(sw_a), .b(sw_b), .c_in(sw_cin), .sub(sw_sub),
                .out_valid(s8_v), .out_ready(1'b1), .sum(s8_sum), .c_out(s8_c), .ovf(s8_o),
                .zero(s8_z));
  add_pipe #(.WIDTH(32), .STAGES(2)) d32 (.clk(clk), .rst(rst), .in_valid(sw_valid),
                .in_ready(s32_ir), .a(sw_a[31:0]), .b(sw_b[31:0]), .c_in(sw_cin), .sub(sw_sub),
                .out_valid(s32_v), .out_ready(1'b1), .sum(s32_sum), .c_out(s32_c), .ovf(s32_o),
                .zero(s32_z));

  typedef struct {
    logic [63:0] sum;
    logic        c, o, z;
    int          cyc;
    int          stl;
  } res_t;

  typedef struct {
    logic [63:0] a, b;
    logic        cin, sub;
    logic [63:0] sum;
    logic        c, o, z;
  } vec_t;

  int   n_chk = 0, n_fail = 0, cyc_n = 0, stall_n = 0;
  res_t q_main[$], q1[$], q8[$], q32[$];
  res_t cur_exp;
  logic acc, hold;
  logic [63:0] h_sum;
  logic h_c, h_o, h_z;

  function automatic res_t model(input logic [63:0] a_, input logic [63:0] b_,
                                 input logic ci, input logic sb, input int w);
    res_t r;
    logic [63:0] m, aa, bx;
    logic [64:0] t;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa = a_ & m;
    bx = (sb ? ~b_ : b_) & m;
    t  = {1'b0, aa} + {1'b0, bx} + {64'b0, (sb ? 1'b1 : ci)};
    r.sum = t[63:0] & m;
    r.c   = t[w];
    r.o   = (aa[w-1] == bx[w-1]) && (r.sum[w-1] != aa[w-1]);
    r.z   = (r.sum == 64'd0);
    r.cyc = 0;
    r.stl = 0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: output valid with no result outstanding", nm);
  endtask

  task automatic cmp_res(input string nm, input logic [63:0] s, input logic c, input logic o,
                         input logic z, input res_t e, input int lat);
    n_chk++;
    if (s !== e.sum || c !== e.c || o !== e.o || z !== e.z || (cyc_n - e.cyc) != lat) begin
      n_fail++;
      $display("FAIL %s: got sum=%h c=%b ovf=%b zero=%b lat=%0d, expected sum=%h c=%b ovf=%b zero=%b lat=%0d",
               nm, s, c, o, z, cyc_n - e.cyc, e.sum, e.c, e.o, e.z, lat);
    end
  endtask

  // Inputs are set at a falling edge; this evaluates the handshakes that the next
  // rising edge will complete, then waits for the following falling edge.
  task automatic cyc();
    res_t e;
    #1;
    acc = 1'b0;
    if (rst) begin
      q_main.delete(); q1.delete(); q8.delete(); q32.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_sum", sum, h_sum);
        chk("hold_flags", {60'd0, out_valid, c_out, ovf, zero}, {60'd0, 1'b1, h_c, h_o, h_z});
      end
      if (out_valid && out_ready) begin
        if (q_main.size() == 0) unexp("main");
        else begin
          e = q_main.pop_front();
          cmp_res("main", sum, c_out, ovf, zero, e, 4 + stall_n - e.stl);
        end
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        hold = 1'b1; h_sum = sum; h_c = c_out; h_o = ovf; h_z = zero;
        stall_n++;
      end else hold = 1'b0;
      if (in_valid && in_ready) begin
        acc = 1'b1;
        e = cur_exp; e.cyc = cyc_n; e.stl = stall_n;
        q_main.push_back(e);
      end
      if (s1_v) begin
        if (q1.size() == 0) unexp("w64s1");
        else begin e = q1.pop_front(); cmp_res("w64s1", s1_sum, s1_c, s1_o, s1_z, e, 1); end
      end
      if (s8_v) begin
        if (q8.size() == 0) unexp("w64s8");
        else begin e = q8.pop_front(); cmp_res("w64s8", s8_sum, s8_c, s8_o, s8_z, e, 8); end
      end
      if (s32_v) begin
        if (q32.size() == 0) unexp("w32s2");
        else begin
          e = q32.pop_front();
          cmp_res("w32s2", {32'd0, s32_sum}, s32_c, s32_o, s32_z, e, 2);
        end
      end
      if (sw_valid) begin
        chk("sweep_in_ready", {61'd0, s1_ir, s8_ir, s32_ir}, 64'd7);
        e = model(sw_a, sw_b, sw_cin, sw_sub, 64); e.cyc = cyc_n;
        q1.push_back(e); q8.push_back(e);
        e = model(sw_a, sw_b, sw_cin, sw_sub, 32); e.cyc = cyc_n;
        q32.push_back(e);
      end
    end
    @(negedge clk);
    cyc_n++;
  endtask

  vec_t        tbl [8];
  logic [63:0] ba [8], bb [8];
  logic        bsub [8], bcin [8];
  int          idx, pushes;

  initial begin
    tbl[0] = '{64'd4096, 64'hFFFF_FFFF_FFFF_FE2D, 1'b0, 1'b0, 64'd3629, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{64'd5, 64'd5, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      ba[i] = {$urandom, $urandom}; bb[i] = {$urandom, $urandom};
      bsub[i] = 1'($urandom_range(1)); bcin[i] = 1'($urandom_range(1));
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    hold = 1'b0; acc = 1'b0; cur_exp = model(64'd0, 64'd0, 1'b0, 1'b0, 64);
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_sum", sum, 64'd0);
    chk("reset_flags", {61'd0, c_out, ovf, zero}, 64'd0);

    // Directed vectors, back to back.
    for (int i = 0; i < 8; i++) begin
      a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].cin; sub = tbl[i].sub; in_valid = 1'b1;
      cur_exp = model(64'd0, 64'd0, 1'b0, 1'b0, 64);
      cur_exp.sum = tbl[i].sum; cur_exp.c = tbl[i].c; cur_exp.o = tbl[i].o; cur_exp.z = tbl[i].z;
      cyc();
    end
    in_valid = 1'b0;
    repeat (6) cyc();

    // Eight back-to-back pairs with a three-cycle consumer stall mid-stream.
    idx = 0;
    for (int t = 0; t < 30; t++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin
        a = ba[idx]; b = bb[idx]; c_in = bcin[idx]; sub = bsub[idx];
        cur_exp = model(a, b, c_in, sub, 64);
      end
      out_ready = !(t >= 6 && t < 9);
      cyc();
      if (acc) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'd8);
    chk("bp_all_drained", 64'(q_main.size()), 64'd0);

    // Reset with two tokens in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = ba[i]; b = bb[i]; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      cur_exp = model(a, b, c_in, sub, 64);
      cyc();
    end
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk("flush_data", {sum[60:0], c_out, ovf, zero}, 64'd0);
    end
    a = 64'd123456789; b = 64'd987654321; c_in = 1'b1; sub = 1'b1; in_valid = 1'b1;
    cur_exp = model(a, b, c_in, sub, 64);
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();
    chk("post_reset_result_seen", 64'(q_main.size()), 64'd0);

    // Random traffic with random back-pressure; operands held until accepted.
    for (int t = 0; t < 300; t++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(3) != 0);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c_in = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
        cur_exp = model(a, b, c_in, sub, 64);
      end
      out_ready = ($urandom_range(3) != 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;

    // Parameter sweep instances.
    pushes = 0;
    for (int t = 0; t < 5000 && pushes < 1000; t++) begin
      sw_valid = ($urandom_range(7) != 0);
      sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
      if ($urandom_range(7) == 0) sw_b = sw_a;
      sw_cin = 1'($urandom_range(1)); sw_sub = 1'($urandom_range(1));
      cyc();
      if (sw_valid) pushes++;
    end
    sw_valid = 1'b0;

    for (int t = 0; t < 40 && (q_main.size() + q1.size() + q8.size() + q32.size()) > 0; t++) cyc();
    chk("all_drained", 64'(q_main.size() + q1.size() + q8.size() + q32.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
